// File: rtl/itag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : itag_ctrl
//  Purpose  : I-cache tag controller. Drives the itag tag RAM (NL lines of
//             TS-bit entries) and consumes its read data. Runs an invalidate
//             sweep after reset and on inv_all, performs single fetch lookups
//             with tag compare, requests and waits for linefills, and writes
//             the new tag once a fill completes.
//  Ports    : nGCLK      - clock, rising edge
//             reset      - synchronous active-high reset
//             req/req_addr/req_rdy - fetch lookup handshake
//             hit/miss   - one-cycle lookup result pulses
//             fill_req/fill_addr/fill_ack/fill_done - linefill handshake
//             inv_all    - invalidate-all request pulse
//             busy       - high in every state except IDLE
//             tag_sel/tag_wdata/tag_we/tag_rdata - tag RAM port
//  Tag entry: [TS-1]=V, [TS-2]=D (always 0 here), [TS-3:0]=addr[31:PSL]
//  Revision : 1.0 - initial release
// ============================================================================
module itag_ctrl #(
    parameter int NL  = 128,
    parameter int LSS = 7,
    parameter int LSH = LSS + 4,
    parameter int PSL = LSH + 1,
    parameter int TS  = 2 + 32 - PSL
) (
    input  logic            nGCLK,
    input  logic            reset,
    input  logic            req,
    input  logic [31:0]     req_addr,
    output logic            req_rdy,
    output logic            hit,
    output logic            miss,
    output logic            fill_req,
    output logic [31:0]     fill_addr,
    input  logic            fill_ack,
    input  logic            fill_done,
    input  logic            inv_all,
    output logic            busy,
    output logic [LSS-1:0]  tag_sel,
    output logic [TS-1:0]   tag_wdata,
    output logic            tag_we,
    input  logic [TS-1:0]   tag_rdata
);

    localparam logic [2:0] c_S_INIT  = 3'd0;
    localparam logic [2:0] c_S_IDLE  = 3'd1;
    localparam logic [2:0] c_S_CMP   = 3'd2;
    localparam logic [2:0] c_S_FREQ  = 3'd3;
    localparam logic [2:0] c_S_FWAIT = 3'd4;
    localparam logic [2:0] c_S_UPD   = 3'd5;

    localparam logic [LSS-1:0] c_LAST_LINE = LSS'(NL - 1);

    logic [2:0]     state_q, state_d;
    logic [LSS-1:0] cnt_q, cnt_d;
    logic           inv_pend_q, inv_pend_d;
    // Only the line-aligned part of the fetch address is ever needed.
    logic [31:5]    addr_q, addr_d;

    logic           w_tag_hit;
    logic           w_unused;

    // The D bit takes no part in the compare; the byte offset is never used.
    assign w_unused  = ^{tag_rdata[TS-2], req_addr[4:0]};

    assign w_tag_hit = tag_rdata[TS-1] && (tag_rdata[TS-3:0] == addr_q[31:PSL]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        inv_pend_d = inv_pend_q;
        addr_d     = addr_q;

        req_rdy    = 1'b0;
        hit        = 1'b0;
        miss       = 1'b0;
        fill_req   = 1'b0;
        fill_addr  = '0;
        busy       = 1'b1;
        tag_sel    = addr_q[LSH:5];
        tag_wdata  = '0;
        tag_we     = 1'b0;

        // An invalidate arriving mid-lookup is remembered and serviced once
        // the controller next returns to IDLE; during INIT it is redundant.
        if (inv_all && (state_q != c_S_INIT) && (state_q != c_S_IDLE)) begin
            inv_pend_d = 1'b1;
        end

        case (state_q)
            c_S_INIT: begin
                tag_sel = cnt_q;
                tag_we  = 1'b1;
                if (cnt_q == c_LAST_LINE) begin
                    cnt_d   = '0;
                    state_d = c_S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            c_S_IDLE: begin
                busy    = 1'b0;
                // Read is issued speculatively so the data lands in CMP.
                tag_sel = req_addr[LSH:5];
                if (inv_all || inv_pend_q) begin
                    inv_pend_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = c_S_INIT;
                end else begin
                    req_rdy = 1'b1;
                    if (req) begin
                        addr_d  = req_addr[31:5];
                        state_d = c_S_CMP;
                    end
                end
            end

            c_S_CMP: begin
                if (w_tag_hit) begin
                    hit     = 1'b1;
                    state_d = c_S_IDLE;
                end else begin
                    miss    = 1'b1;
                    state_d = c_S_FREQ;
                end
            end

            c_S_FREQ: begin
                fill_req  = 1'b1;
                fill_addr = {addr_q, 5'b0};
                // fill_done is not looked at here, so one coinciding with
                // the ack is dropped.
                if (fill_ack) begin
                    state_d = c_S_FWAIT;
                end
            end

            c_S_FWAIT: begin
                if (fill_done) begin
                    state_d = c_S_UPD;
                end
            end

            c_S_UPD: begin
                tag_we    = 1'b1;
                tag_wdata = {1'b1, 1'b0, addr_q[31:PSL]};
                state_d   = c_S_IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = c_S_INIT;
            end
        endcase
    end

    always_ff @(posedge nGCLK) begin
        if (reset) begin
            state_q    <= c_S_INIT;
            cnt_q      <= '0;
            inv_pend_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inv_pend_q <= inv_pend_d;
            addr_q     <= addr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_itag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_itag_ctrl
//  Purpose  : Self-checking bench for itag_ctrl. Models the tag RAM and keeps
//             an abstract picture of cache contents (valid/tag per line) to
//             predict hit/miss, fill addresses and tag writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_itag_ctrl;

    logic        nGCLK = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_rdy, hit, miss, fill_req;
    logic [31:0] fill_addr;
    logic        fill_ack = 1'b0;
    logic        fill_done = 1'b0;
    logic        inv_all = 1'b0;
    logic        busy;
    logic [6:0]  tag_sel;
    logic [21:0] tag_wdata;
    logic        tag_we;
    logic [21:0] tag_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Tag RAM: registered read, write-first not required.
    logic [21:0] mem [128];

    // Reference picture of the cache: which lines are valid and their tag.
    bit          mv [128];
    logic [19:0] mt [128];

    itag_ctrl dut (
        .nGCLK     (nGCLK),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_rdy   (req_rdy),
        .hit       (hit),
        .miss      (miss),
        .fill_req  (fill_req),
        .fill_addr (fill_addr),
        .fill_ack  (fill_ack),
        .fill_done (fill_done),
        .inv_all   (inv_all),
        .busy      (busy),
        .tag_sel   (tag_sel),
        .tag_wdata (tag_wdata),
        .tag_we    (tag_we),
        .tag_rdata (tag_rdata)
    );

    always #5 nGCLK = ~nGCLK;

    always @(posedge nGCLK) begin
        if (tag_we) mem[tag_sel] <= tag_wdata;
        tag_rdata <= mem[tag_sel];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge nGCLK);
        #2;
    endtask

    // Entered in the first INIT cycle (counter at 0). Counts write cycles and
    // checks the index sequence and zero data; ends in IDLE.
    task automatic sweep(input bit pulse_inv);
        int i   = 0;
        int bad = 0;
        while (tag_we === 1'b1 && i < 300) begin
            inv_all = pulse_inv && (i == 40);
            #1;
            if (tag_sel !== i[6:0] || tag_wdata !== 22'd0 || busy !== 1'b1) bad++;
            i++;
            step();
        end
        inv_all = 1'b0;
        #1;
        chk("sweep_len", i, 128);
        chk("sweep_seq", bad, 0);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_rdy", {31'd0, req_rdy}, 1);
        for (int k = 0; k < 128; k++) mv[k] = 1'b0;
    endtask

    // One complete fetch lookup from IDLE. Optionally pulses inv_all in the
    // first FWAIT cycle, raises fill_done together with fill_ack, or resets
    // the controller while it waits in FWAIT.
    task automatic lookup(input logic [31:0] a, input int ack_dly, input int done_dly,
                          input bit inv_fw, input bit done_w_ack, input bit rst_fw);
        logic [31:0] idx;
        logic [31:0] tg;
        bit          exp_hit;
        int          bad = 0;
        idx     = (a >> 5) % 128;
        tg      = a >> 12;
        exp_hit = mv[idx] && (mt[idx] == tg[19:0]);
        #1;
        chk("idle_rdy_pre", {31'd0, req_rdy}, 1);
        req      = 1'b1;
        req_addr = a;
        step();
        req      = 1'b0;
        req_addr = $urandom;
        #1;
        chk("hit", {31'd0, hit}, {31'd0, exp_hit});
        chk("miss", {31'd0, miss}, {31'd0, !exp_hit});
        if (exp_hit) begin
            step();
            return;
        end
        step();
        for (int d = 0; d <= ack_dly; d++) begin
            fill_ack  = (d == ack_dly);
            fill_done = (d == ack_dly) && done_w_ack;
            #1;
            if (d == 0) chk("fill_addr", fill_addr, a & ~32'd31);
            if (fill_req !== 1'b1 || fill_addr !== (a & ~32'd31) || tag_we !== 1'b0) bad++;
            step();
        end
        fill_ack  = 1'b0;
        fill_done = 1'b0;
        inv_all   = inv_fw;
        #1;
        chk("freq_hold", bad, 0);
        chk("fill_req_drop", {31'd0, fill_req}, 0);
        if (rst_fw) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            #1;
            chk("rst_fill_req", {31'd0, fill_req}, 0);
            chk("rst_sel0", {25'd0, tag_sel}, 0);
            chk("rst_we", {31'd0, tag_we}, 1);
            sweep(1'b0);
            return;
        end
        for (int d = 0; d < done_dly; d++) begin
            if (tag_we !== 1'b0 || fill_req !== 1'b0) bad++;
            step();
            inv_all = 1'b0;
            #1;
        end
        chk("fwait_quiet", bad, 0);
        fill_done = 1'b1;
        step();
        fill_done = 1'b0;
        inv_all   = 1'b0;
        #1;
        chk("upd_we", {31'd0, tag_we}, 1);
        chk("upd_sel", {25'd0, tag_sel}, idx);
        chk("upd_wdata", {10'd0, tag_wdata}, (32'd1 << 21) | tg);
        mv[idx] = 1'b1;
        mt[idx] = tg[19:0];
        step();
        #1;
        chk("post_upd_we", {31'd0, tag_we}, 0);
        if (inv_fw) begin
            chk("pend_rdy", {31'd0, req_rdy}, 0);
            step();
            sweep(1'b0);
        end else begin
            chk("post_upd_idle", {31'd0, busy}, 0);
        end
    endtask

    initial begin
        for (int k = 0; k < 128; k++) begin
            mem[k] = {2'b10, 20'($urandom)};
            mv[k]  = 1'b0;
            mt[k]  = '0;
        end

        // Reset state and the power-on sweep.
        step();
        #1;
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_we", {31'd0, tag_we}, 1);
        chk("rst_sel", {25'd0, tag_sel}, 0);
        chk("rst_outs", {28'd0, req_rdy, hit, miss, fill_req}, 0);
        chk("rst_fill_addr", fill_addr, 0);
        reset = 1'b0;
        sweep(1'b0);

        // Cold miss, fill, then the retried lookup hits (twice, back-to-back).
        lookup(32'h0000_1A40, 0, 0, 1'b0, 1'b0, 1'b0);
        lookup(32'h0000_1A40, 0, 0, 1'b0, 1'b0, 1'b0);
        lookup(32'h0000_1A44, 0, 0, 1'b0, 1'b0, 1'b0);

        // Alias on the same index replaces the tag; the old address then misses.
        lookup(32'h0000_2A40, 1, 1, 1'b0, 1'b0, 1'b0);
        lookup(32'h0000_1A40, 0, 0, 1'b0, 1'b0, 1'b0);

        // Slow ack with a fill_done coinciding with it, done 3 cycles later.
        lookup(32'h1234_5660, 5, 3, 1'b0, 1'b1, 1'b0);
        lookup(32'h1234_5660, 0, 0, 1'b0, 1'b0, 1'b0);

        // inv_all during FWAIT: fill finishes, sweep follows, line is gone.
        lookup(32'h0000_3A40, 0, 2, 1'b1, 1'b0, 1'b0);
        lookup(32'h0000_3A40, 0, 0, 1'b0, 1'b0, 1'b0);

        // inv_all beats a simultaneous request; a repeat inv_all in INIT is dropped.
        inv_all  = 1'b1;
        req      = 1'b1;
        req_addr = 32'h0000_3A40;
        #1;
        chk("inv_prio_rdy", {31'd0, req_rdy}, 0);
        step();
        inv_all = 1'b0;
        req     = 1'b0;
        sweep(1'b1);
        step();
        #1;
        chk("inv_init_ignored", {31'd0, busy}, 0);

        // Reset while waiting for fill_done.
        lookup(32'h0000_4A40, 2, 0, 1'b0, 1'b0, 1'b1);
        lookup(32'h0000_4A40, 0, 0, 1'b0, 1'b0, 1'b0);

        // Randomized lookups over a few hot indices and tags.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [6:0]  ix;
            logic [19:0] tgr;
            bit          dwa;
            ix  = ($urandom_range(0, 1) == 0) ? 7'h52 : 7'($urandom_range(0, 127));
            tgr = 20'($urandom_range(1, 3));
            a   = {tgr, ix, 5'($urandom)};
            dwa = ($urandom_range(0, 3) == 0);
            lookup(a, $urandom_range(0, 4), dwa ? $urandom_range(1, 3) : $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0), dwa, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
